aes_key_expand_seq: RTL and testbench
=====================================

Name: aes_key_expand_seq

Overview:
- Iterative AES-128 key-schedule engine.
- Sits directly upstream of the round datapath and the encrypt final round stage.
- Accepts a 128-bit cipher key and produces round keys 0..10 one per accepted handshake, using the FIPS-197 schedule.
- Holds the round-10 key in a stable register (final_key) that drives the final round's round_key input until the next key is loaded.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128; other values unsupported.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only in IDLE.
- cipher_key  input  128  initial key; [127:96]=w0, byte [127:120] first (FIPS-197 order).
- busy  output  1  high while a schedule is in progress.
- key_valid  output  1  round_key/round_idx are valid.
- key_ready  input  1  consumer accepts the current round key.
- round_idx  output  4  index of the presented round key, 0..10.
- round_key  output  128  current round key.
- final_key  output  128  round-10 key; stable until the next accepted start.
- done  output  1  one-cycle pulse when the round-10 key is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: busy=0, key_valid=0, round_idx=0, round_key=0, final_key=0, done=0, state=IDLE. A reset mid-schedule aborts immediately; no partial final_key update.
- States: IDLE and RUN.
- IDLE:
  - start=1 registers cipher_key into round_key, sets round_idx=0, key_valid=1, busy=1, and moves to RUN.
  - Latency from start to the first valid key is 1 cycle.
- RUN, handshake: a transfer occurs on a cycle with key_valid&&key_ready.
  - Without a transfer, round_key, round_idx and key_valid hold exactly.
- RUN, transfer with round_idx<10: next key computed from the current round_key.
  - t = SubWord(RotWord(w3)) ^ {rcon[round_idx+1],24'h0}
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
  - round_idx increments. Next key is presented the following cycle, so the throughput is 1 key/cycle with key_ready held high.
- RUN, transfer with round_idx==10:
  - Pulse done=1 for 1 cycle.
  - Clear key_valid and busy, return to IDLE.
  - final_key was already loaded with round_key when round_idx became 10, i.e. final_key is valid from the same cycle the round-10 key is presented.
- rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. This is a constant table indexed by round; not computed by xtime.
- start while busy is ignored; no restart and no error flag. start in the same cycle as the final transfer is also ignored; re-assert start in IDLE.
- cipher_key is only sampled on the accepted start cycle; later changes have no effect.
- done and key_valid are never both high in the same cycle, because done coincides with key_valid dropping.
- round_idx never exceeds 10 and does not wrap.
- SubWord uses a combinational S-box; the key path from round_key register to round_key register is the single registered stage.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10
  - rcon table (10 x 8-bit)
  - 256-entry S-box constant/function, shared with sub_bytes
  - word/byte slicing helpers for FIPS-197 column order
- One sub-module: aes_key_sub_word. Combinational, 32-bit in/out, four S-box lookups on the rotated word.
- FSM, counter and handshake live in the top module.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, key_ready=1.
  - Round 0 = same key, 1 cycle after start.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, 11 cycles after start.
  - done pulses once; final_key equals round 10.
- Same key, key_ready toggled 1,0,0,1,... pseudo-randomly.
  - Keys and round_idx hold during stalls.
  - The sequence of accepted keys is identical to the scenario above.
  - done occurs only on the 11th transfer.
- All-zero key.
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start re-asserted at round_idx=4 with a different key.
  - Ignored; the schedule completes with the original key's round-10 value.
  - A new start in IDLE then reloads, and final_key updates only when the new round 10 is reached.
- rst asserted at round_idx=6.
  - Next cycle all outputs are 0, state IDLE, final_key=0.
  - A subsequent start produces the full correct sequence.
- start held high continuously.
  - Back-to-back schedules, each of 11 keys.
  - Exactly one idle cycle (key_valid=0) between done and the next round-0 key.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants: round count, key-schedule rcon table,
//                forward S-box and FIPS-197 word/byte helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

   localparam int AES_NR = 10;

   // Key-schedule controller states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ks_state_t;

   // Round constants for rounds 1..10 (element 0 is round 1)
   localparam logic [0:9][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Forward S-box, element 0 is the MSB so SBOX[x] is S(x)
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Column word i (0..3) of a 128-bit state/key; w0 occupies [127:96]
   function automatic logic [31:0] key_word(input logic [127:0] k, input int i);
      return k[32*(3-i) +: 32];
   endfunction

   // Cyclic left rotation by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0]
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Round constant byte for round 1..10; zero outside that range
   function automatic logic [7:0] rcon_byte(input logic [3:0] round);
      if (round >= 4'd1 && round <= 4'd10)
         return RCON[round - 4'd1];
      return 8'h00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sub_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_sub_word
//  Description : Combinational SubWord(RotWord(w)) for the AES key schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   logic [31:0] rotated;

   assign rotated = rot_word(word_in);

   // One S-box lookup per byte of the rotated word
   for (genvar b = 0; b < 4; b++) begin : g_sbox
      assign word_out[8*b +: 8] = sbox(rotated[8*b +: 8]);
   end

endmodule
`default_nettype wire

// File: rtl/aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand_seq
//  Description : Iterative AES-128 key schedule. Presents round keys 0..10,
//                one per valid/ready transfer, and holds the round-10 key in
//                final_key for the final round stage.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_expand_seq
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] cipher_key,
   output logic         busy,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [3:0]   round_idx,
   output logic [127:0] round_key,
   output logic [127:0] final_key,
   output logic         done
);

   localparam logic [3:0] LAST_IDX = 4'(NR);

   ks_state_t    state, state_n;
   logic         busy_n, valid_n, done_n;
   logic [3:0]   idx_n;
   logic [127:0] key_n, final_n;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sub_rot, t;
   logic [31:0]  nw0, nw1, nw2, nw3;
   logic [127:0] next_key;
   logic         xfer;

   assign w0 = key_word(round_key, 0);
   assign w1 = key_word(round_key, 1);
   assign w2 = key_word(round_key, 2);
   assign w3 = key_word(round_key, 3);

   aes_key_sub_word u_sub_word (
      .word_in  (w3),
      .word_out (sub_rot)
   );

   // Single combinational round of the schedule from the current round key
   assign t        = sub_rot ^ {rcon_byte(round_idx + 4'd1), 24'h000000};
   assign nw0      = w0 ^ t;
   assign nw1      = w1 ^ nw0;
   assign nw2      = w2 ^ nw1;
   assign nw3      = w3 ^ nw2;
   assign next_key = {nw0, nw1, nw2, nw3};

   assign xfer = key_valid && key_ready;

   // Next-state and next-output decode; every register holds by default
   always_comb begin
      state_n = state;
      busy_n  = busy;
      valid_n = key_valid;
      idx_n   = round_idx;
      key_n   = round_key;
      final_n = final_key;
      done_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               key_n   = cipher_key;
               idx_n   = 4'd0;
               valid_n = 1'b1;
               busy_n  = 1'b1;
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               if (round_idx == LAST_IDX) begin
                  valid_n = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  key_n = next_key;
                  idx_n = round_idx + 4'd1;
                  // Capture the last key as it is produced so final_key is
                  // valid in the same cycle the round-10 key is presented
                  if (round_idx + 4'd1 == LAST_IDX)
                     final_n = next_key;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         key_valid <= 1'b0;
         round_idx <= 4'd0;
         round_key <= 128'h0;
         final_key <= 128'h0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         busy      <= busy_n;
         key_valid <= valid_n;
         round_idx <= idx_n;
         round_key <= key_n;
         final_key <= final_n;
         done      <= done_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expand_seq
//  Description : Scoreboard bench for the iterative AES-128 key schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_key_expand_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] cipher_key;
   logic         busy;
   logic         key_valid;
   logic         key_ready;
   logic [3:0]   round_idx;
   logic [127:0] round_key;
   logic [127:0] final_key;
   logic         done;

   aes_key_expand_seq #(.NR(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cipher_key (cipher_key),
      .busy       (busy),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .round_idx  (round_idx),
      .round_key  (round_key),
      .final_key  (final_key),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]   idx;
      logic [127:0] key;
      logic         chk;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic exp_done = 1'b0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   logic [127:0] fips_rk [11];
   logic [127:0] zero_rk [11];
   logic         zero_chk[11];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every presented key with the scoreboard head
   always @(negedge clk) begin
      if (exp_done) begin
         check("done_pulse", {127'h0, done}, 128'h1);
         check("done_valid_low", {127'h0, key_valid}, 128'h0);
         exp_done = 1'b0;
      end else if (done) begin
         check("spurious_done", {127'h0, done}, 128'h0);
      end
      if (!rst && key_valid) begin
         if (sbq.size() == 0) begin
            check("unexpected_key_valid", {127'h0, key_valid}, 128'h0);
         end else begin
            check("round_idx", {124'h0, round_idx}, {124'h0, sbq[0].idx});
            if (sbq[0].chk)
               check("round_key", round_key, sbq[0].key);
            if (sbq[0].idx == 4'd10)
               check("final_key_at_r10", final_key, sbq[0].key);
            if (key_ready) begin
               if (sbq[0].idx == 4'd10) exp_done = 1'b1;
               void'(sbq.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_fips();
      for (int r = 0; r <= 10; r++) sbq.push_back('{idx: 4'(r), key: fips_rk[r], chk: 1'b1});
   endtask

   task automatic push_zero();
      for (int r = 0; r <= 10; r++) sbq.push_back('{idx: 4'(r), key: zero_rk[r], chk: zero_chk[r]});
   endtask

   // Start pulse; cipher_key is scrambled afterwards since only the start cycle counts
   task automatic pulse_start(input logic [127:0] k);
      start      = 1'b1;
      cipher_key = k;
      tick();
      start      = 1'b0;
      cipher_key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while (busy && i < budget) begin tick(); i++; end
      if (busy) check("timeout_idle", {127'h0, busy}, 128'h0);
      tick();
   endtask

   task automatic wait_idx(input logic [3:0] target, input int budget);
      int i = 0;
      while (!(key_valid && round_idx == target) && i < budget) begin tick(); i++; end
      if (!(key_valid && round_idx == target))
         check("timeout_idx", {124'h0, round_idx}, {124'h0, target});
   endtask

   initial begin
      int n;
      int gap;
      int ri;
      logic [3:0] pat;

      fips_rk[0]  = FIPS_KEY;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      for (int r = 0; r <= 10; r++) begin zero_rk[r] = 128'h0; zero_chk[r] = 1'b0; end
      zero_chk[0]  = 1'b1;
      zero_chk[1]  = 1'b1; zero_rk[1]  = 128'h62636363626363636263636362636363;
      zero_chk[10] = 1'b1; zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

      rst = 1'b1; start = 1'b0; key_ready = 1'b0; cipher_key = '0;
      repeat (3) tick();
      check("rst_busy",      {127'h0, busy},      128'h0);
      check("rst_key_valid", {127'h0, key_valid}, 128'h0);
      check("rst_round_idx", {124'h0, round_idx}, 128'h0);
      check("rst_round_key", round_key,           128'h0);
      check("rst_final_key", final_key,           128'h0);
      check("rst_done",      {127'h0, done},      128'h0);
      rst = 1'b0;
      tick();

      // FIPS-197 key, ready always high; latency checks
      push_fips();
      key_ready = 1'b1;
      pulse_start(FIPS_KEY);
      check("lat_r0_valid", {127'h0, key_valid}, 128'h1);
      check("lat_r0_idx",   {124'h0, round_idx}, 128'h0);
      n = 1;
      while (!(key_valid && round_idx == 4'd10) && n < 30) begin tick(); n++; end
      check("lat_r10_cycles", 128'(n), 128'd11);
      check("final_key_r10", final_key, fips_rk[10]);
      wait_idle(20);

      // Same key with stalls: 1,0,0,1 then pseudo-random ready
      push_fips();
      key_ready = 1'b1;
      pulse_start(FIPS_KEY);
      pat = 4'b1001;
      ri  = 0;
      while (busy && ri < 200) begin
         key_ready = (ri < 4) ? pat[3 - ri] : 1'($urandom_range(0, 1));
         tick();
         ri++;
      end
      if (busy) check("timeout_stall", {127'h0, busy}, 128'h0);
      key_ready = 1'b1;
      tick();

      // All-zero key
      push_zero();
      pulse_start(128'h0);
      wait_idle(20);
      check("final_key_zero", final_key, zero_rk[10]);

      // start while busy at round 4 is ignored
      push_fips();
      pulse_start(FIPS_KEY);
      wait_idx(4'd4, 20);
      start = 1'b1; cipher_key = 128'h0;
      tick();
      start = 1'b0;
      wait_idle(20);
      check("ignored_start_final", final_key, fips_rk[10]);
      push_zero();
      pulse_start(128'h0);
      wait_idx(4'd5, 20);
      check("final_key_hold", final_key, fips_rk[10]);
      wait_idle(20);

      // Reset in the middle of a schedule
      push_fips();
      pulse_start(FIPS_KEY);
      wait_idx(4'd6, 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sbq.delete();
      check("midrst_busy",      {127'h0, busy},      128'h0);
      check("midrst_key_valid", {127'h0, key_valid}, 128'h0);
      check("midrst_round_idx", {124'h0, round_idx}, 128'h0);
      check("midrst_round_key", round_key,           128'h0);
      check("midrst_final_key", final_key,           128'h0);
      check("midrst_done",      {127'h0, done},      128'h0);
      push_fips();
      pulse_start(FIPS_KEY);
      wait_idle(20);

      // start held high: back-to-back schedules with one idle cycle between
      push_fips();
      push_fips();
      start = 1'b1; cipher_key = FIPS_KEY;
      n = 0;
      while (!done && n < 40) begin tick(); n++; end
      check("b2b_first_done", {127'h0, done}, 128'h1);
      gap = 0;
      while (!key_valid && gap < 5) begin tick(); gap++; end
      check("b2b_idle_gap", 128'(gap), 128'd1);
      check("b2b_restart_idx", {124'h0, round_idx}, 128'h0);
      wait_idx(4'd10, 20);
      start = 1'b0;
      wait_idle(20);
      tick();
      check("b2b_final", final_key, fips_rk[10]);
      check("sb_drained", 128'(sbq.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
